wb_mem_responder: RTL and testbench

- Pipelined Wishbone responder (slave) backed by a word-addressed on-chip memory.
- It sits on the far end of the bus from the core's bus interface unit and serves back-to-back cacheline bursts.
- Requests are accepted one per cycle, queued in order, and acknowledged after a configurable latency.
- The stall output applies backpressure when the response queue is full.

---
 rtl/wb_mem_responder.sv | 120 ++++++++++++
 tb/tb_wb_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder serving a word-addressed on-chip memory.
// Latency: LATENCY cycles from request acceptance to ack; acks strictly in order, one per cycle.
// Backpressure: o_wb_stall is high while FIFO_DEPTH requests are outstanding (no same-cycle bypass).
module wb_mem_responder #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int LATENCY       = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                       i_wb_clk,
    input  logic                       i_wb_rst,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    input  logic                       i_wb_we,
    input  logic [WB_DATA_WIDTH/8-1:0] i_wb_sel,
    input  logic [WB_ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [WB_DATA_WIDTH-1:0]   i_wb_data,
    output logic [WB_DATA_WIDTH-1:0]   o_wb_data,
    output logic                       o_wb_ack,
    output logic                       o_wb_stall
);

    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Countdown only has to hold LATENCY-1; keep at least one bit for LATENCY=1.
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [WB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [WB_DATA_WIDTH-1:0] dat_q [FIFO_DEPTH];
    logic [WB_DATA_WIDTH-1:0] dat_d [FIFO_DEPTH];
    logic [CD_W-1:0]          cd_q  [FIFO_DEPTH];
    logic [CD_W-1:0]          cd_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]         rptr_q, rptr_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [IDX_W-1:0]         idx;
    logic [WB_DATA_WIDTH-1:0] rd_word;
    logic                     accept;
    logic                     ack;

    // Upper address bits alias and byte-offset bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_wb_addr;

    assign idx        = i_wb_addr[OFF_W +: IDX_W];
    assign rd_word    = mem[idx];
    assign o_wb_stall = (count_q == CNT_FULL);
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign ack        = i_wb_cyc & (count_q != '0) & (cd_q[rptr_q] == '0);
    assign o_wb_ack   = ack;
    assign o_wb_data  = ack ? dat_q[rptr_q] : '0;

    // Byte-lane writes commit at the accept edge so later reads in the burst see them.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst && accept && i_wb_we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (i_wb_sel[b]) begin
                    mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    // Next-state for the response queue: age countdowns, push captured word, pop on ack, flush on cyc low.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            dat_d[i] = dat_q[i];
            cd_d[i]  = (cd_q[i] != '0) ? cd_q[i] - CD_W'(1) : cd_q[i];
        end
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (!i_wb_cyc) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                dat_d[wptr_q] = rd_word;
                cd_d[wptr_q]  = CD_INIT;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (ack) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(ack);
        end
    end

    // Queue control state; reset empties the queue, entry payloads need no reset.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Queue entry payloads: captured word and remaining latency.
    always_ff @(posedge i_wb_clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            dat_q[i] <= dat_d[i];
            cd_q[i]  <= cd_d[i];
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (LATENCY 2 and 8, FIFO_DEPTH 4).
// Reference model: per-request due times and a word array, checked every cycle.
// Requests are held until the model says they were accepted.
module tb_wb_mem_responder;

    localparam int FD   = 4;
    localparam int LAT0 = 2;
    localparam int LAT1 = 8;
    localparam int QN   = 64;

    logic        clk;
    logic        rst   [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] adr   [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        ack   [2];
    logic        stall [2];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] mm [2][1024];
    logic [31:0] pd [2][QN];
    int          pr [2][QN];
    int          hd [2];
    int          tl [2];
    int          lat [2];
    int          now;

    // observations of the DUT
    bit          acc_last [2];
    int          n_ack [2];
    logic [31:0] last_dat [2];
    int          last_ack_at [2];
    int          last_acc_at [2];
    int          out_obs [2];
    int          max_out [2];

    wb_mem_responder #(.LATENCY(LAT0), .FIFO_DEPTH(FD)) u_dut0 (
        .i_wb_clk(clk), .i_wb_rst(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .i_wb_we(we[0]), .i_wb_sel(sel[0]), .i_wb_addr(adr[0]), .i_wb_data(wdat[0]),
        .o_wb_data(rdat[0]), .o_wb_ack(ack[0]), .o_wb_stall(stall[0])
    );

    wb_mem_responder #(.LATENCY(LAT1), .FIFO_DEPTH(FD)) u_dut1 (
        .i_wb_clk(clk), .i_wb_rst(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .i_wb_we(we[1]), .i_wb_sel(sel[1]), .i_wb_addr(adr[1]), .i_wb_data(wdat[1]),
        .o_wb_data(rdat[1]), .o_wb_ack(ack[1]), .o_wb_stall(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    // One bus cycle: compare both DUTs against the model, then advance the model past the edge.
    task automatic cycle();
        bit eack [2];
        bit acc  [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int          sz;
            logic        e_stall;
            logic [31:0] e_dat;
            sz      = tl[d] - hd[d];
            e_stall = (sz == FD);
            eack[d] = cyc[d] && (sz != 0) && (pr[d][hd[d] % QN] <= now);
            e_dat   = eack[d] ? pd[d][hd[d] % QN] : 32'h0;
            chk($sformatf("ack%0d@%0d", d, now), 32'(ack[d]), 32'(eack[d]));
            chk($sformatf("stall%0d@%0d", d, now), 32'(stall[d]), 32'(e_stall));
            chk($sformatf("data%0d@%0d", d, now), rdat[d], e_dat);
            acc[d] = cyc[d] && stb[d] && !e_stall && !rst[d];
            if (ack[d]) begin
                n_ack[d]++;
                last_dat[d]    = rdat[d];
                last_ack_at[d] = now;
                out_obs[d]--;
            end
            if (acc[d]) begin
                last_acc_at[d] = now;
                out_obs[d]++;
                if (out_obs[d] > max_out[d]) max_out[d] = out_obs[d];
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (rst[d] || !cyc[d]) begin
                hd[d]      = 0;
                tl[d]      = 0;
                out_obs[d] = 0;
            end else begin
                if (eack[d]) hd[d]++;
                if (acc[d]) begin
                    int w;
                    w = int'((adr[d] >> 2) % 1024);
                    pd[d][tl[d] % QN] = mm[d][w];
                    pr[d][tl[d] % QN] = now + lat[d];
                    tl[d]++;
                    if (we[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (sel[d][b]) mm[d][w][8*b +: 8] = wdat[d][8*b +: 8];
                        end
                    end
                end
            end
            acc_last[d] = acc[d];
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    // Present one request and hold it until accepted; stb stays high for back-to-back use.
    task automatic req(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] s);
        cyc[d]  = 1'b1;
        stb[d]  = 1'b1;
        we[d]   = w;
        adr[d]  = a;
        wdat[d] = dat;
        sel[d]  = s;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (acc_last[d]) return;
        end
        timeout_fail($sformatf("req%0d_accept", d));
    endtask

    task automatic drain(input int d);
        stb[d] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (tl[d] == hd[d]) return;
            cycle();
        end
        timeout_fail($sformatf("drain%0d", d));
    endtask

    initial begin
        int          n0;
        int          t0;
        logic [31:0] a;
        logic [31:0] v;
        lat[0] = LAT0;
        lat[1] = LAT1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
            hd[d] = 0; tl[d] = 0; n_ack[d] = 0; out_obs[d] = 0; max_out[d] = 0;
            acc_last[d] = 1'b0; last_dat[d] = 32'h0; last_ack_at[d] = 0; last_acc_at[d] = 0;
        end
        now = 0;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        // reset state: idle outputs
        cycle();
        chk("reset_ack0", 32'(ack[0]), 32'h0);
        chk("reset_stall1", 32'(stall[1]), 32'h0);

        // single read, LATENCY 2
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        drain(0);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        t0 = last_acc_at[0];
        drain(0);
        chk("t1_latency", 32'(last_ack_at[0] - t0), 32'd2);
        chk("t1_data", last_dat[0], 32'hDEADBEEF);

        // 4-beat write burst then 4-beat read burst, back to back
        n0 = n_ack[0];
        req(0, 1'b1, 32'h100, 32'h11111111, 4'hF);
        req(0, 1'b1, 32'h104, 32'h22222222, 4'hF);
        req(0, 1'b1, 32'h108, 32'h33333333, 4'hF);
        req(0, 1'b1, 32'h10C, 32'h44444444, 4'hF);
        for (int i = 0; i < 4; i++) req(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
        drain(0);
        chk("t2_acks", 32'(n_ack[0] - n0), 32'd8);
        chk("t2_last", last_dat[0], 32'h44444444);

        // LATENCY 8: six back-to-back reads hit the stall
        for (int i = 0; i < 6; i++) req(1, 1'b1, 32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
        drain(1);
        max_out[1] = 0;
        n0 = n_ack[1];
        for (int i = 0; i < 6; i++) req(1, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0);
        drain(1);
        chk("t3_acks", 32'(n_ack[1] - n0), 32'd6);
        chk("t3_max_outstanding", 32'(max_out[1]), 32'd4);
        chk("t3_last", last_dat[1], 32'hC0DE0005);

        // partial-byte write
        req(0, 1'b1, 32'h0, 32'h0, 4'hF);
        req(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101);
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drain(0);
        chk("t4_sel", last_dat[0], 32'h00BB00DD);

        // cyc dropped with two reads in flight
        for (int i = 0; i < 4; i++) req(0, 1'b1, 32'h300 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 4'hF);
        drain(0);
        n0 = n_ack[0];
        req(0, 1'b0, 32'h300, 32'h0, 4'h0);
        req(0, 1'b0, 32'h304, 32'h0, 4'h0);
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        cycle();
        cycle();
        chk("t5_no_ack", 32'(n_ack[0] - n0), 32'd0);
        req(0, 1'b0, 32'h308, 32'h0, 4'h0);
        t0 = last_acc_at[0];
        drain(0);
        chk("t5_latency", 32'(last_ack_at[0] - t0), 32'd2);
        chk("t5_data", last_dat[0], 32'h5A5A0002);

        // reset with three writes outstanding
        req(1, 1'b1, 32'h400, 32'h0BAD0001, 4'hF);
        req(1, 1'b1, 32'h404, 32'h0BAD0002, 4'hF);
        req(1, 1'b1, 32'h408, 32'h0BAD0003, 4'hF);
        stb[1] = 1'b0;
        rst[1] = 1'b1;
        cycle();
        rst[1] = 1'b0;
        chk("t6_ack", 32'(ack[1]), 32'h0);
        chk("t6_stall", 32'(stall[1]), 32'h0);
        n0 = n_ack[1];
        for (int i = 0; i < 3; i++) req(1, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'h0);
        drain(1);
        chk("t6_acks", 32'(n_ack[1] - n0), 32'd3);
        chk("t6_data", last_dat[1], 32'h0BAD0003);

        // randomized traffic with aliasing, gaps, cyc drops and resets
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) req(d, 1'b1, 32'(4 * w), $urandom, 4'hF);
            drain(d);
            for (int k = 0; k < 150; k++) begin
                int r;
                r = $urandom_range(0, 39);
                if (r == 0) begin
                    stb[d] = 1'b0;
                    rst[d] = 1'b1;
                    cycle();
                    rst[d] = 1'b0;
                end else if (r < 3) begin
                    stb[d] = 1'b0;
                    cyc[d] = 1'b0;
                    cycle();
                end else if (r < 8) begin
                    stb[d] = 1'b0;
                    cyc[d] = 1'b1;
                    cycle();
                end else begin
                    a       = $urandom;
                    a[11:2] = 10'($urandom_range(0, 15));
                    v       = $urandom;
                    req(d, 1'($urandom_range(0, 1)), a, v, 4'($urandom_range(0, 15)));
                end
            end
            cyc[d] = 1'b1;
            drain(d);
            cyc[d] = 1'b0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
